// File: rtl/qspi_pkg.sv
// QSPI target shared definitions: opcodes, state encoding, phase lengths.
// Build option: QSPI_TARGET_WRITE_EN adds the 0x02 page-write path.
package qspi_pkg;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_QREAD = 8'h6B;

    localparam int ADDR_LEN  = 24;
    localparam int DUMMY_CYC = 8;
    localparam int CNT_W     = 5;

    localparam logic [CNT_W-1:0] CNT_BYTE_END  = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_ADDR_END  = CNT_W'(ADDR_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_DUMMY_END = CNT_W'(DUMMY_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_IGNORE
`ifdef QSPI_TARGET_WRITE_EN
        , ST_WDATA
`endif
    } state_t;

endpackage

// File: rtl/qspi_sync.sv
// Two-flop synchronizers for the QSPI pads plus SCK/CSB edge pulses.
// Build option: none (QSPI_TARGET_WRITE_EN does not affect this block).
module qspi_sync
    import qspi_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_csb,
    input  logic       i_sck,
    input  logic [3:0] i_sio,
    output logic       o_csb,
    output logic       o_csb_fall,
    output logic       o_sck_rise,
    output logic       o_sck_fall,
    output logic [3:0] o_sio
);

    logic       r_csb_m;
    logic       r_csb_s;
    logic       r_csb_d;
    logic       r_sck_m;
    logic       r_sck_s;
    logic       r_sck_d;
    logic [3:0] r_sio_m;
    logic [3:0] r_sio_s;

    // Metastability chains; reset to idle pad levels (csb high, sck low).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_csb_m <= 1'b1;
            r_csb_s <= 1'b1;
            r_csb_d <= 1'b1;
            r_sck_m <= 1'b0;
            r_sck_s <= 1'b0;
            r_sck_d <= 1'b0;
            r_sio_m <= 4'b0000;
            r_sio_s <= 4'b0000;
        end else begin
            r_csb_m <= i_csb;
            r_csb_s <= r_csb_m;
            r_csb_d <= r_csb_s;
            r_sck_m <= i_sck;
            r_sck_s <= r_sck_m;
            r_sck_d <= r_sck_s;
            r_sio_m <= i_sio;
            r_sio_s <= r_sio_m;
        end
    end

    assign o_csb      = r_csb_s;
    assign o_csb_fall = r_csb_d & ~r_csb_s;
    assign o_sck_rise = r_sck_s & ~r_sck_d;
    assign o_sck_fall = ~r_sck_s & r_sck_d;
    assign o_sio      = r_sio_s;

endmodule

// File: rtl/qspi_target.sv
// QSPI memory target: 0x03 single read, 0x6B quad-output read.
// Build option: QSPI_TARGET_WRITE_EN adds opcode 0x02 and mem_we/mem_wdata.
module qspi_target
    import qspi_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pad_qspi_csb,
    input  logic              pad_qspi_sck,
    input  logic [3:0]        sio_i,
    output logic [3:0]        sio_o,
    output logic [3:0]        sio_oe,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              cmd_err
`ifdef QSPI_TARGET_WRITE_EN
    ,
    output logic              mem_we,
    output logic [7:0]        mem_wdata
`endif
);

    localparam logic [MEM_AW-1:0] ADDR_ONE = MEM_AW'(1);

    logic             w_csb;
    logic             w_csb_fall;
    logic             w_sck_rise;
    logic             w_sck_fall;
    logic [3:0]       w_sio;
    logic             w_sio0;
    logic [7:0]       w_shift_nxt;
    logic [23:0]      w_addr_nxt;
    logic             w_bit;

    state_t           r_state;
    logic [CNT_W-1:0] r_bitcnt;
    logic [6:0]       r_shift;
    logic [22:0]      r_addr;
    logic             r_quad;
    logic             r_req_d;
    logic [7:0]       r_next;
    logic [7:0]       r_cur;
`ifdef QSPI_TARGET_WRITE_EN
    logic             r_wr;
`endif

    qspi_sync u_sync (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_csb      (pad_qspi_csb),
        .i_sck      (pad_qspi_sck),
        .i_sio      (sio_i),
        .o_csb      (w_csb),
        .o_csb_fall (w_csb_fall),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_sio      (w_sio)
    );

    assign w_sio0      = w_sio[0];
    assign w_shift_nxt = {r_shift, w_sio0};
    assign w_addr_nxt  = {r_addr, w_sio0};
    // First bit of a byte comes straight from the prefetch buffer.
    assign w_bit = (r_bitcnt == '0) ? r_next[7]
                                    : r_cur[3'd7 - r_bitcnt[2:0]];

    // Protocol FSM with registered pad and memory outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_addr   <= '0;
            r_quad   <= 1'b0;
            r_req_d  <= 1'b0;
            r_next   <= '0;
            r_cur    <= '0;
            sio_o    <= 4'b0000;
            sio_oe   <= 4'b0000;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            cmd_err  <= 1'b0;
`ifdef QSPI_TARGET_WRITE_EN
            r_wr      <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
`endif
        end else begin
            mem_req <= 1'b0;
            cmd_err <= 1'b0;
            r_req_d <= mem_req;
            if (r_req_d) begin
                r_next <= mem_rdata;
            end
`ifdef QSPI_TARGET_WRITE_EN
            mem_we <= 1'b0;
            if (mem_we) begin
                mem_addr <= mem_addr + ADDR_ONE;
            end
`endif
            if (w_csb) begin
                r_state  <= ST_IDLE;
                r_bitcnt <= '0;
                sio_oe   <= 4'b0000;
                sio_o    <= 4'b0000;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_csb_fall) begin
                            r_state  <= ST_CMD;
                            r_bitcnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sck_rise) begin
                            r_shift <= w_shift_nxt[6:0];
                            if (r_bitcnt == CNT_BYTE_END) begin
                                r_bitcnt <= '0;
                                if (w_shift_nxt == OP_READ ||
                                    w_shift_nxt == OP_QREAD) begin
                                    r_state <= ST_ADDR;
                                    r_quad  <= (w_shift_nxt == OP_QREAD);
`ifdef QSPI_TARGET_WRITE_EN
                                    r_wr    <= 1'b0;
                                end else if (w_shift_nxt == OP_WRITE) begin
                                    r_state <= ST_ADDR;
                                    r_quad  <= 1'b0;
                                    r_wr    <= 1'b1;
`endif
                                end else begin
                                    r_state <= ST_IGNORE;
                                    cmd_err <= 1'b1;
                                end
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_sck_rise) begin
                            r_addr <= w_addr_nxt[22:0];
                            if (r_bitcnt == CNT_ADDR_END) begin
                                r_bitcnt <= '0;
                                mem_addr <= w_addr_nxt[MEM_AW-1:0];
`ifdef QSPI_TARGET_WRITE_EN
                                if (r_wr) begin
                                    r_state <= ST_WDATA;
                                end else begin
                                    mem_req <= 1'b1;
                                    r_state <= r_quad ? ST_DUMMY
                                                      : ST_RDATA;
                                end
`else
                                mem_req <= 1'b1;
                                r_state <= r_quad ? ST_DUMMY : ST_RDATA;
`endif
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (w_sck_rise) begin
                            if (r_bitcnt == CNT_DUMMY_END) begin
                                r_bitcnt <= '0;
                                r_state  <= ST_RDATA;
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (w_sck_fall) begin
                            sio_oe <= r_quad ? 4'b1111 : 4'b0010;
                            // Byte start: promote prefetch, fetch the next.
                            if (r_bitcnt == '0) begin
                                r_cur    <= r_next;
                                mem_req  <= 1'b1;
                                mem_addr <= mem_addr + ADDR_ONE;
                            end
                            if (r_quad) begin
                                sio_o    <= (r_bitcnt == '0) ? r_next[7:4]
                                                             : r_cur[3:0];
                                r_bitcnt <= (r_bitcnt == '0) ? CNT_W'(1)
                                                             : '0;
                            end else begin
                                sio_o    <= {2'b00, w_bit, 1'b0};
                                r_bitcnt <= (r_bitcnt == CNT_BYTE_END)
                                            ? '0 : r_bitcnt + 1'b1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        sio_oe <= 4'b0000;
                    end
`ifdef QSPI_TARGET_WRITE_EN
                    ST_WDATA: begin
                        if (w_sck_rise) begin
                            r_shift <= w_shift_nxt[6:0];
                            if (r_bitcnt == CNT_BYTE_END) begin
                                r_bitcnt  <= '0;
                                mem_wdata <= w_shift_nxt;
                                mem_we    <= 1'b1;
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
